reg_bank_scanner: RTL

//   Read-side companion to the register-bank write path. Walks the 16x16 register

---
 rtl/reg_bank_scanner_if.sv | 11 +
 rtl/reg_bank_scanner.sv | 86 ++++++++
 2 files changed

// File: rtl/reg_bank_scanner_if.sv
// reg_bank_scanner_if: register-bank read port shared between the bank and the scanner.
interface reg_bank_scanner_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  modport master (output rd_addr, rd_en, input rd_data);
  modport slave  (input rd_addr, rd_en, output rd_data);
endinterface

// File: rtl/reg_bank_scanner.sv
// reg_bank_scanner: walks the register bank and presents each {addr, value} pair for display.
// Optional SCAN_CHECKSUM_EN adds a running checksum port over the captured values.
module reg_bank_scanner #(
  parameter int NREGS       = 16,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 16,
  parameter int RD_LAT      = 1,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_mode,
  input  logic              step_n,
  reg_bank_scanner_if.master bank,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
`ifdef SCAN_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, CAPTURE, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] idx, idx_n, rd_addr_q;
  logic [7:0] wait_cnt;
  logic [31:0] hold_cnt;
  logic [2:0] key_s;
  logic step_pulse, hold_done, hold_exit, last;
  assign step_pulse = key_s[2] & ~key_s[1];
  assign last       = idx == ADDR_W'(NREGS - 1);
  assign hold_done  = hold_cnt == 32'(HOLD_CYCLES - 1);
  assign hold_exit  = auto_mode ? hold_done : step_pulse;
  assign busy       = state inside {ADDR, WAIT, CAPTURE, HOLD};
  assign done       = state == DONE;
  assign bank.rd_en   = state == ADDR;
  assign bank.rd_addr = rd_addr_q;
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE:    if (start) begin state_n = ADDR; idx_n = '0; end
      ADDR:    state_n = RD_LAT == 0 ? CAPTURE : WAIT;
      WAIT:    state_n = wait_cnt == 8'(RD_LAT - 1) ? CAPTURE : WAIT;
      CAPTURE: state_n = HOLD;
      HOLD:    if (hold_exit) begin state_n = last ? DONE : ADDR; idx_n = last ? idx : idx + ADDR_W'(1); end
      default: state_n = IDLE;
    endcase
  end
  // disp_* load on the edge entering CAPTURE, when rd_data is valid for the current address
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      rd_addr_q  <= '0;
      wait_cnt   <= '0;
      hold_cnt   <= '0;
      key_s      <= 3'b111;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      key_s    <= {key_s[1:0], step_n};
      wait_cnt <= state == WAIT ? wait_cnt + 8'd1 : 8'd0;
      hold_cnt <= state == HOLD ? (hold_done ? hold_cnt : hold_cnt + 32'd1) : 32'd0;
      if (state_n == ADDR) rd_addr_q <= idx_n;
      if (state == IDLE && start) disp_valid <= 1'b0;
      if (state_n == CAPTURE) begin
        disp_addr  <= idx;
        disp_data  <= bank.rd_data;
        disp_valid <= 1'b1;
      end
    end
  end
`ifdef SCAN_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) checksum <= '0;
    else if (state_n == CAPTURE) checksum <= checksum + bank.rd_data;
  end
`endif
endmodule
